// File: rtl/io_slave_mux.sv
// io_slave_mux: bridges one upstream bus master onto eight memory-mapped
// I/O devices sharing a common device bus.
//
// Accesses in 0xFFD0_0000-0xFFD7_FFFF are decoded to device s_adr_i[18:16].
// The device sees a one-hot chip select and the low 16 address bits. Other
// addresses and device timeouts end with a terminating response.
//
// Optional build macro: IOMUX_BUSERR_EN
//   defined   - timeout/unmapped access raises s_err_o
//   undefined - timeout/unmapped access acks with zero data; s_err_o stays 0
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   s_cyc_i/s_stb_i/s_we_i         upstream cycle, strobe, write enable
//   s_sel_i/s_adr_i/s_dat_i        upstream byte selects, address, write data
//   s_ack_o/s_err_o/s_dat_o        upstream acknowledge, error, read data
//   m_cyc_o/m_stb_o/m_we_o         device bus cycle, strobe, write enable
//   m_cs_o                         one-hot device select
//   m_sel_o/m_adr_o/m_dat_o        device byte selects, local address, write data
//   m_ack_i                        per-device acknowledge
//   m_dat_i                        per-device read data, device n at [32n+31:32n]
module io_slave_mux #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         s_cyc_i,
    input  logic         s_stb_i,
    input  logic         s_we_i,
    input  logic [3:0]   s_sel_i,
    input  logic [31:0]  s_adr_i,
    input  logic [31:0]  s_dat_i,
    output logic         s_ack_o,
    output logic         s_err_o,
    output logic [31:0]  s_dat_o,
    output logic         m_cyc_o,
    output logic         m_stb_o,
    output logic         m_we_o,
    output logic [7:0]   m_cs_o,
    output logic [3:0]   m_sel_o,
    output logic [15:0]  m_adr_o,
    output logic [31:0]  m_dat_o,
    input  logic [7:0]   m_ack_i,
    input  logic [255:0] m_dat_i
);

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        s_ack_q, s_ack_d;
    logic        s_err_q, s_err_d;
    logic [31:0] s_dat_q, s_dat_d;
    logic        m_cyc_q, m_cyc_d;
    logic        m_stb_q, m_stb_d;
    logic        m_we_q, m_we_d;
    logic [7:0]  m_cs_q, m_cs_d;
    logic [3:0]  m_sel_q, m_sel_d;
    logic [15:0] m_adr_q, m_adr_d;
    logic [31:0] m_dat_q, m_dat_d;

    logic        mapped;
    logic        sel_ack;
    logic [7:0]  cnt_inc;
    logic        term;     // end the access with a timeout/unmapped response
    logic        clear_m;  // release the device bus

    assign mapped  = (s_adr_i[31:19] == 13'h1FFA);
    assign sel_ack = m_ack_i[idx_q];
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        s_ack_d = s_ack_q;
        s_err_d = s_err_q;
        s_dat_d = s_dat_q;
        m_cyc_d = m_cyc_q;
        m_stb_d = m_stb_q;
        m_we_d  = m_we_q;
        m_cs_d  = m_cs_q;
        m_sel_d = m_sel_q;
        m_adr_d = m_adr_q;
        m_dat_d = m_dat_q;
        term    = 1'b0;
        clear_m = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (s_cyc_i && s_stb_i) begin
                    if (mapped) begin
                        idx_d   = s_adr_i[18:16];
                        m_cs_d  = 8'b1 << s_adr_i[18:16];
                        m_sel_d = s_sel_i;
                        m_we_d  = s_we_i;
                        m_adr_d = s_adr_i[15:0];
                        m_dat_d = s_dat_i;
                        m_cyc_d = 1'b1;
                        m_stb_d = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = StActive;
                    end else begin
                        term    = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StActive: begin
                cnt_d = cnt_inc;
                // Selected ack beats both abort and timeout in the same cycle.
                if (sel_ack) begin
                    clear_m = 1'b1;
                    s_ack_d = 1'b1;
                    s_dat_d = m_dat_i[{idx_q, 5'd0} +: 32];
                    state_d = StDone;
                end else if (!s_cyc_i) begin
                    clear_m = 1'b1;
                    state_d = StIdle;
                end else if (cnt_inc == TIMEOUT) begin
                    clear_m = 1'b1;
                    term    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!s_stb_i) begin
                    s_ack_d = 1'b0;
                    s_err_d = 1'b0;
                    s_dat_d = 32'h0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear_m) begin
            m_cyc_d = 1'b0;
            m_stb_d = 1'b0;
            m_we_d  = 1'b0;
            m_cs_d  = 8'h0;
            m_sel_d = 4'h0;
            m_adr_d = 16'h0;
            m_dat_d = 32'h0;
        end

        if (term) begin
`ifdef IOMUX_BUSERR_EN
            s_err_d = 1'b1;
`else
            s_ack_d = 1'b1;
`endif
            s_dat_d = 32'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            s_ack_q <= 1'b0;
            s_err_q <= 1'b0;
            s_dat_q <= 32'h0;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_cs_q  <= 8'h0;
            m_sel_q <= 4'h0;
            m_adr_q <= 16'h0;
            m_dat_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            s_ack_q <= s_ack_d;
            s_err_q <= s_err_d;
            s_dat_q <= s_dat_d;
            m_cyc_q <= m_cyc_d;
            m_stb_q <= m_stb_d;
            m_we_q  <= m_we_d;
            m_cs_q  <= m_cs_d;
            m_sel_q <= m_sel_d;
            m_adr_q <= m_adr_d;
            m_dat_q <= m_dat_d;
        end
    end

    assign s_ack_o = s_ack_q;
    assign s_err_o = s_err_q;
    assign s_dat_o = s_dat_q;
    assign m_cyc_o = m_cyc_q;
    assign m_stb_o = m_stb_q;
    assign m_we_o  = m_we_q;
    assign m_cs_o  = m_cs_q;
    assign m_sel_o = m_sel_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;

endmodule
